key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Input conditioning stage directly upstream of the 16-bit adder lab control FSM.
- Takes raw active-low push-buttons (Run, LoadB, Clear) and raw slide switches SW[15:0] from the board.
- Produces metastability-safe, debounced key levels and single-cycle press/release pulses; the control FSM consumes the pulses in place of raw button levels.
- Also produces a 2-flop-synchronised copy of the switches for the operand path.

Parameters:
- N_KEYS, 3, number of push-buttons conditioned; bit 0 Run, bit 1 LoadB, bit 2 Clear.
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronised cycles required to accept a press or release; legal range >= 2.
- SW_WIDTH, 16, switch bus width.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- Key_n  input  N_KEYS  raw buttons, active-low, asynchronous to Clk
- SW_raw  input  SW_WIDTH  raw slide switches, asynchronous
- Key_level  output  N_KEYS  debounced key state, active-high (1 = held)
- Key_press  output  N_KEYS  one-cycle pulse on each accepted press
- Key_release  output  N_KEYS  one-cycle pulse on each accepted release
- SW_sync  output  SW_WIDTH  SW_raw through two flops

Behaviour:
- Reset is on Clk only: Reset, synchronous, active-high; clock Clk.
- While Reset is high, all of the following hold:
  - Key_level, Key_press, Key_release and SW_sync are 0.
  - Synchroniser flops hold "released", i.e. an internal active-high value of 0.
  - Per-key FSMs are in IDLE and counters are 0.
- Reset asserted mid-debounce or mid-hold aborts immediately, with no pulse.
- A key physically held through reset deassertion is re-debounced from IDLE and yields a fresh Key_press.
- Synchroniser: ~Key_n passes through 2 flops (s1, s2); SW_raw passes through 2 flops to SW_sync.
  - A raw change captured at edge k is visible on s2/SW_sync after edge k+1.
- Per-key FSM, evaluated every edge, with independent instances per key:
  - IDLE: Key_level=0. If s2=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - If s2=0, return to IDLE (bounce rejected, no pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED.
    - Else cnt++.
  - PRESSED: Key_level=1. If s2=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT:
    - If s2=1, return to PRESSED (no pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else cnt++.
- Outputs are registered:
  - Key_level=1 in PRESSED and RELEASE_WAIT.
  - Key_press is high for exactly the first cycle in PRESSED entered from PRESS_WAIT.
  - Key_release is high for exactly the first cycle in IDLE entered from RELEASE_WAIT.
  - Key_press and Key_release are never both high for the same key.
  - Returning to PRESSED from RELEASE_WAIT never pulses.
- Latency: raw press captured at edge k and held stable gives Key_press/Key_level high after edge k+2+DEBOUNCE_CYCLES. Release latency is symmetric.
- Counter width is $clog2(DEBOUNCE_CYCLES); the counter saturates and never wraps.
- Simultaneous presses on different keys are conditioned independently, and pulses may coincide.

Decomposition:
- Package adder_io_pkg holds:
  - enum debounce_state_t {DB_IDLE, DB_PRESS_WAIT, DB_PRESSED, DB_RELEASE_WAIT};
  - localparam key indices KEY_RUN=0, KEY_LOADB=1, KEY_CLEAR=2;
  - default DEBOUNCE_CYCLES constant.
- Sub-module key_debounce: one synchroniser, FSM and counter, outputs level/press/release, parameter DEBOUNCE_CYCLES.
- key_conditioner instantiates N_KEYS copies via generate, plus the switch synchroniser.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: Key_n[0] 1->0 before edge 0, held -> Key_press[0]=1 for exactly the one cycle after edge 6; Key_level[0]=1 from edge 6; other keys 0.
- Bounce rejection: Key_n[1] low for 3 cycles, high 1, low 2, then high -> no Key_press[1], Key_level[1] stays 0.
- Clean release: after accepted press, Key_n[0] 0->1 held -> Key_release[0] single pulse after edge 6 relative to release, Key_level[0] falls the same edge; a release glitch of 2 cycles first gives no release pulse.
- Switch sync: SW_raw 16'h0000->16'hA5C3 before edge 0 -> SW_sync=16'hA5C3 after edge 1, 0 after edge 0.
- Reset mid-operation: Reset high during PRESS_WAIT and again during PRESSED -> all outputs 0 next cycle, no pulses; key still held after Reset drops -> Key_press 6 edges later.
- Simultaneous keys: Key_n=3'b000 at edge 0 -> Key_press=3'b111 in the same cycle after edge 6, each a single pulse.

Source files
------------

// File: rtl/adder_io_pkg.sv
// adder_io_pkg: shared types and constants for the adder lab input conditioning
package adder_io_pkg;
  typedef enum logic [1:0] {DB_IDLE, DB_PRESS_WAIT, DB_PRESSED, DB_RELEASE_WAIT} debounce_state_t;
  localparam int KEY_RUN = 0;
  localparam int KEY_LOADB = 1;
  localparam int KEY_CLEAR = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus debounce FSM for one active-low button
module key_debounce
  import adder_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q;
  debounce_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      DB_IDLE: if (s2_q) begin
        state_d = DB_PRESS_WAIT;
        cnt_d = '0;
      end
      DB_PRESS_WAIT:
        if (!s2_q) state_d = DB_IDLE;
        else if (cnt_q == CNT_LAST) state_d = DB_PRESSED;
        else cnt_d = cnt_q + 1'b1;
      DB_PRESSED: if (!s2_q) begin
        state_d = DB_RELEASE_WAIT;
        cnt_d = '0;
      end
      DB_RELEASE_WAIT:
        if (s2_q) state_d = DB_PRESSED;
        else if (cnt_q == CNT_LAST) state_d = DB_IDLE;
        else cnt_d = cnt_q + 1'b1;
      default: state_d = DB_IDLE;
    endcase
    level_d = state_d == DB_PRESSED || state_d == DB_RELEASE_WAIT;
    press_d = state_q == DB_PRESS_WAIT && state_d == DB_PRESSED;
    release_d = state_q == DB_RELEASE_WAIT && state_d == DB_IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      state_q <= DB_IDLE;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q <= ~key_n;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      release_q <= release_d;
    end
  end
  assign level = level_q;
  assign press_pulse = press_q;
  assign release_pulse = release_q;
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounced key levels/pulses and synchronised switches for the adder control path
module key_conditioner
  import adder_io_pkg::*;
#(
  parameter int N_KEYS = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SW_WIDTH = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N_KEYS-1:0]   Key_n,
  input  logic [SW_WIDTH-1:0] SW_raw,
  output logic [N_KEYS-1:0]   Key_level,
  output logic [N_KEYS-1:0]   Key_press,
  output logic [N_KEYS-1:0]   Key_release,
  output logic [SW_WIDTH-1:0] SW_sync
);
  logic [SW_WIDTH-1:0] sw_s1_q, sw_sync_q;
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .Clk(Clk),
      .Reset(Reset),
      .key_n(Key_n[k]),
      .level(Key_level[k]),
      .press_pulse(Key_press[k]),
      .release_pulse(Key_release[k])
    );
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_s1_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_s1_q <= SW_raw;
      sw_sync_q <= sw_s1_q;
    end
  end
  assign SW_sync = sw_sync_q;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: vector table with a scoreboard queue, DEBOUNCE_CYCLES=4
module tb_key_conditioner;
  import adder_io_pkg::*;
  localparam logic [2:0] RUN = 3'(1 << KEY_RUN);
  localparam logic [2:0] LDB = 3'(1 << KEY_LOADB);
  localparam logic [2:0] CLR = 3'(1 << KEY_CLEAR);
  localparam logic [2:0] ALL = RUN | LDB | CLR;
  logic Clk = 1'b0, Reset = 1'b1;
  logic [2:0] Key_n = 3'b111;
  logic [15:0] SW_raw = '0;
  logic [2:0] Key_level, Key_press, Key_release;
  logic [15:0] SW_sync;
  key_conditioner #(.N_KEYS(3), .DEBOUNCE_CYCLES(4), .SW_WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .Key_n(Key_n), .SW_raw(SW_raw),
    .Key_level(Key_level), .Key_press(Key_press), .Key_release(Key_release), .SW_sync(SW_sync)
  );
  always #5 Clk = ~Clk;
  typedef struct packed {
    logic rst;
    logic [2:0] kn;
    logic [15:0] sw;
    logic [2:0] lvl, prs, rls;
    logic [15:0] sws;
  } vec_t;
  vec_t vecs[$];
  vec_t exp_q[$];
  logic [15:0] sw_p1 = '0;
  int n_vec = 0, n_bad = 0;
  // Expected SW_sync comes from a two-stage delay model that reset clears
  task automatic add(input logic rst, input logic [2:0] kn, input logic [15:0] sw,
                     input logic [2:0] lvl, input logic [2:0] prs, input logic [2:0] rls, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst = rst; v.kn = kn; v.sw = sw; v.lvl = lvl; v.prs = prs; v.rls = rls;
      v.sws = rst ? 16'h0 : sw_p1;
      sw_p1 = rst ? 16'h0 : sw;
      vecs.push_back(v);
    end
  endtask
  task automatic check();
    vec_t e;
    e = exp_q.pop_front();
    n_vec++;
    if ({Key_level, Key_press, Key_release, SW_sync} !== {e.lvl, e.prs, e.rls, e.sws}) begin
      n_bad++;
      $display("FAIL vec %0d: got level=%b press=%b release=%b sw_sync=%h, want level=%b press=%b release=%b sw_sync=%h",
               n_vec - 1, Key_level, Key_press, Key_release, SW_sync, e.lvl, e.prs, e.rls, e.sws);
    end
  endtask
  initial begin
    // keys held through reset, simultaneous press/release, switch sync
    add(1, 3'b000, 16'hFFFF, 0, 0, 0, 2);
    add(0, 3'b000, 16'hA5C3, 0, 0, 0, 6);
    add(0, 3'b000, 16'hA5C3, ALL, ALL, 0, 1);
    add(0, 3'b000, 16'hA5C3, ALL, 0, 0, 2);
    add(0, 3'b111, 16'h5A3C, ALL, 0, 0, 6);
    add(0, 3'b111, 16'h5A3C, 0, 0, ALL, 1);
    add(0, 3'b111, 16'h5A3C, 0, 0, 0, 2);
    // clean Run press, 2-cycle release glitch, clean release
    add(0, ~RUN, 16'h1234, 0, 0, 0, 6);
    add(0, ~RUN, 16'h1234, RUN, RUN, 0, 1);
    add(0, ~RUN, 16'h1234, RUN, 0, 0, 2);
    add(0, 3'b111, 16'h1234, RUN, 0, 0, 2);
    add(0, ~RUN, 16'h1234, RUN, 0, 0, 4);
    add(0, 3'b111, 16'h1234, RUN, 0, 0, 6);
    add(0, 3'b111, 16'h1234, 0, 0, RUN, 1);
    add(0, 3'b111, 16'h1234, 0, 0, 0, 2);
    // LoadB bounce: low 3, high 1, low 2, then high
    add(0, ~LDB, 16'h0F0F, 0, 0, 0, 3);
    add(0, 3'b111, 16'h0F0F, 0, 0, 0, 1);
    add(0, ~LDB, 16'h0F0F, 0, 0, 0, 2);
    add(0, 3'b111, 16'h0F0F, 0, 0, 0, 6);
    // Clear: reset during PRESS_WAIT, then during PRESSED, key held throughout
    add(0, ~CLR, 16'hBEEF, 0, 0, 0, 4);
    add(1, ~CLR, 16'hBEEF, 0, 0, 0, 1);
    add(0, ~CLR, 16'hBEEF, 0, 0, 0, 6);
    add(0, ~CLR, 16'hBEEF, CLR, CLR, 0, 1);
    add(0, ~CLR, 16'hBEEF, CLR, 0, 0, 2);
    add(1, ~CLR, 16'hBEEF, 0, 0, 0, 1);
    add(0, ~CLR, 16'hBEEF, 0, 0, 0, 6);
    add(0, ~CLR, 16'hBEEF, CLR, CLR, 0, 1);
    add(0, ~CLR, 16'hBEEF, CLR, 0, 0, 2);
    add(0, 3'b111, 16'hBEEF, CLR, 0, 0, 6);
    add(0, 3'b111, 16'hBEEF, 0, 0, CLR, 1);
    add(0, 3'b111, 16'hBEEF, 0, 0, 0, 2);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      Reset = vecs[i].rst;
      Key_n = vecs[i].kn;
      SW_raw = vecs[i].sw;
      exp_q.push_back(vecs[i]);
      @(posedge Clk);
      #1;
      check();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
